// File: rtl/noc_sink_monitor.sv
// rtl/noc_sink_monitor.sv - per-port delivered-packet counter and latency statistics with one-cycle read port
// Optional feature: define NOC_SINK_MISROUTE_CHECK_EN for the sticky dest-vs-port misroute flag.
`ifndef PORTS
`define PORTS 5
`endif

package noc_sink_pkg;
  localparam int NPORTS = `PORTS;
  localparam int DEST_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TS_W   = 16;

  typedef struct packed {
    logic              valid;
    logic              measure;
    logic [DEST_W-1:0] dest;
    logic [TS_W-1:0]   timestamp;
  } packet_t;
endpackage

module noc_sink_monitor
  import noc_sink_pkg::*;
#(
  parameter int PORTS        = noc_sink_pkg::NPORTS,
  parameter int TS_WIDTH     = noc_sink_pkg::TS_W,
  parameter int CNT_WIDTH    = 32,
  parameter int ACC_WIDTH    = 48,
  parameter int DRAIN_CYCLES = 1024,
  localparam int RD_W        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  packet_t              pkt_out [0:PORTS-1],
  input  logic                 start,
  input  logic                 stop,
  output logic [TS_WIDTH-1:0]  time_now,
  output logic [1:0]           state_o,
  input  logic                 rd_en,
  input  logic [RD_W-1:0]      rd_port,
  output logic                 rd_valid,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [ACC_WIDTH-1:0] rd_lat_sum,
  output logic [TS_WIDTH-1:0]  rd_lat_min,
  output logic [TS_WIDTH-1:0]  rd_lat_max,
  output logic                 misroute_err
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_clear;
  logic                w_load_drain;
  logic                w_count_en;
  logic [DW-1:0]       r_drain;
  logic [TS_WIDTH-1:0] r_time;

  logic [CNT_WIDTH-1:0] w_cnt_all [PORTS];
  logic [ACC_WIDTH-1:0] w_sum_all [PORTS];
  logic [TS_WIDTH-1:0]  w_min_all [PORTS];
  logic [TS_WIDTH-1:0]  w_max_all [PORTS];

  assign time_now   = r_time;
  assign state_o    = r_state;
  assign w_count_en = (r_state == S_MEASURE) || (r_state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_time <= '0;
    else     r_time <= r_time + TS_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_load_drain = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_MEASURE;
          w_clear     = 1'b1;
        end
      end
      S_MEASURE: begin
        if (stop) begin
          w_state_nxt  = S_DRAIN;
          w_load_drain = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == '0) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_drain <= '0;
    else if (w_load_drain)                      r_drain <= DW'(DRAIN_CYCLES - 1);
    else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - DW'(1);
  end

  // Each port keeps its own stats; all ports can update on the same edge.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [ACC_WIDTH-1:0] r_sum;
    logic [TS_WIDTH-1:0]  r_min;
    logic [TS_WIDTH-1:0]  r_max;
    logic [TS_WIDTH-1:0]  w_lat;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_hit;

    assign w_hit     = pkt_out[p].valid && pkt_out[p].measure && w_count_en;
    assign w_lat     = r_time - pkt_out[p].timestamp;
    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_WIDTH + 1 - TS_WIDTH){1'b0}}, w_lat};

    always_ff @(posedge clk or posedge rst) begin
      if (rst || w_clear) begin
        r_cnt <= '0;
        r_sum <= '0;
        r_min <= '1;
        r_max <= '0;
      end else if (w_hit) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
        r_sum <= w_sum_ext[ACC_WIDTH] ? '1 : w_sum_ext[ACC_WIDTH-1:0];
        if (w_lat < r_min) r_min <= w_lat;
        if (w_lat > r_max) r_max <= w_lat;
      end
    end

    assign w_cnt_all[p] = r_cnt;
    assign w_sum_all[p] = r_sum;
    assign w_min_all[p] = r_min;
    assign w_max_all[p] = r_max;
  end

`ifdef NOC_SINK_MISROUTE_CHECK_EN
  logic [PORTS-1:0] w_misroute;
  logic             r_misroute;

  for (genvar p = 0; p < PORTS; p++) begin : g_mis
    assign w_misroute[p] = pkt_out[p].valid && (pkt_out[p].dest != DEST_W'(p));
  end

  // A misroute seen on the clearing edge itself still raises the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_misroute <= 1'b0;
    else if (w_clear) r_misroute <= |w_misroute;
    else if (|w_misroute) r_misroute <= 1'b1;
  end

  assign misroute_err = r_misroute;
`else
  logic [PORTS-1:0] w_unused_dest;

  for (genvar p = 0; p < PORTS; p++) begin : g_unused
    assign w_unused_dest[p] = ^pkt_out[p].dest;
  end

  assign misroute_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      rd_count   <= '0;
      rd_lat_sum <= '0;
      rd_lat_min <= '0;
      rd_lat_max <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (int'(rd_port) < PORTS) begin
          rd_count   <= w_cnt_all[rd_port];
          rd_lat_sum <= w_sum_all[rd_port];
          rd_lat_min <= w_min_all[rd_port];
          rd_lat_max <= w_max_all[rd_port];
        end else begin
          rd_count   <= '0;
          rd_lat_sum <= '0;
          rd_lat_min <= '0;
          rd_lat_max <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_sink_monitor.sv
// tb/tb_noc_sink_monitor.sv - self-checking bench for noc_sink_monitor
// Expected misroute behaviour follows NOC_SINK_MISROUTE_CHECK_EN.
module tb_noc_sink_monitor;
  import noc_sink_pkg::*;

  localparam int NP   = NPORTS;
  localparam int RD_W = (NP > 1) ? $clog2(NP) : 1;
`ifdef NOC_SINK_MISROUTE_CHECK_EN
  localparam logic MR_EXP = 1'b1;
`else
  localparam logic MR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  packet_t         pkt [0:NP-1];
  logic            start, stop, rd_en;
  logic [RD_W-1:0] rd_port;
  logic [15:0]     time_now;
  logic [1:0]      state_o;
  logic            rd_valid;
  logic [31:0]     rd_count;
  logic [47:0]     rd_lat_sum;
  logic [15:0]     rd_lat_min, rd_lat_max;
  logic            misroute_err;

  noc_sink_monitor dut (
    .clk(clk), .rst(rst), .pkt_out(pkt), .start(start), .stop(stop),
    .time_now(time_now), .state_o(state_o), .rd_en(rd_en), .rd_port(rd_port),
    .rd_valid(rd_valid), .rd_count(rd_count), .rd_lat_sum(rd_lat_sum),
    .rd_lat_min(rd_lat_min), .rd_lat_max(rd_lat_max), .misroute_err(misroute_err)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] cnt;
    logic [47:0] sum;
    logic [15:0] mn;
    logic [15:0] mx;
  } stats_t;
  stats_t exp_q [$];

  typedef struct {
    int          port;
    int          lat;
    bit          v;
    bit          m;
    logic [31:0] cnt;
    logic [47:0] sum;
    logic [15:0] mn;
    logic [15:0] mx;
  } vec_t;
  vec_t vt [8];

  // Independent model of the free-running timestamp.
  logic [15:0] tb_now;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_now <= 16'd0;
    else     tb_now <= tb_now + 16'd1;
  end

  always @(posedge clk) begin
    stats_t e;
    #1;
    if (!rst && rd_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 required 0");
      end else begin
        e = exp_q.pop_front();
        if (rd_count !== e.cnt || rd_lat_sum !== e.sum || rd_lat_min !== e.mn || rd_lat_max !== e.mx) begin
          n_err++;
          $display("FAIL rd_data: got cnt=%0d sum=%0d min=%0h max=%0h required cnt=%0d sum=%0d min=%0h max=%0h",
                   rd_count, rd_lat_sum, rd_lat_min, rd_lat_max, e.cnt, e.sum, e.mn, e.mx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic clear_pkts();
    for (int p = 0; p < NP; p++) pkt[p] = '0;
  endtask

  task automatic send(input int p, input int lat, input bit v, input bit m, input int dest);
    pkt[p].valid     = v;
    pkt[p].measure   = m;
    pkt[p].dest      = DEST_W'(dest);
    pkt[p].timestamp = tb_now - 16'(lat);
    @(negedge clk);
    pkt[p] = '0;
  endtask

  task automatic rd(input int p, input logic [31:0] c, input logic [47:0] s,
                    input logic [15:0] mn, input logic [15:0] mx);
    stats_t e;
    e.cnt = c; e.sum = s; e.mn = mn; e.mx = mx;
    rd_en   = 1'b1;
    rd_port = RD_W'(p);
    exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_latency", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_until(input logic [15:0] t, input string name);
    int i = 0;
    while (tb_now !== t && i < 70000) begin
      @(negedge clk);
      i++;
    end
    if (tb_now !== t) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got tb_now=%0d required %0d", name, tb_now, t);
    end
  endtask

  task automatic pulse(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  logic [15:0] t0;

  initial begin
    vt[0] = '{2, 5,     1, 1, 1, 5,     16'd5,    16'd9 - 16'd4};
    vt[1] = '{2, 9,     1, 1, 2, 14,    16'd5,    16'd9};
    vt[2] = '{2, 3,     1, 1, 3, 17,    16'd3,    16'd9};
    vt[3] = '{2, 1,     0, 1, 3, 17,    16'd3,    16'd9};
    vt[4] = '{2, 1,     1, 0, 3, 17,    16'd3,    16'd9};
    vt[5] = '{0, 0,     1, 1, 1, 0,     16'd0,    16'd0};
    vt[6] = '{1, 65535, 1, 1, 1, 65535, 16'hFFFF, 16'hFFFF};
    vt[7] = '{2, 20,    1, 1, 4, 37,    16'd3,    16'd20};

    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_en = 1'b0; rd_port = '0;
    clear_pkts();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_time", 64'(time_now), 64'd0);
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_count", 64'(rd_count), 64'd0);
    chk("reset_misroute", 64'(misroute_err), 64'd0);
    rd(0, 32'd0, 48'd0, 16'hFFFF, 16'd0);
    @(negedge clk);
    chk("rd_valid_drop", 64'(rd_valid), 64'd0);

    wait_until(16'd65520, "idle");
    chk("idle_state", 64'(state_o), 64'd0);
    chk("idle_time", 64'(time_now), 64'(tb_now));
    pulse(1'b1, 1'b0);
    chk("start_measure", 64'(state_o), 64'd1);

    wait_until(16'hFFFF, "pre_wrap");
    chk("time_max", 64'(time_now), 64'hFFFF);
    @(negedge clk);
    chk("time_wrap", 64'(time_now), 64'd0);

    // Stamp 65530 arriving at time_now 4 gives latency 10 across the wrap.
    wait_until(16'd4, "wrap_pkt");
    send(3, 10, 1'b1, 1'b1, 3);
    rd(3, 32'd1, 48'd10, 16'd10, 16'd10);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].port, vt[i].lat, vt[i].v, vt[i].m, vt[i].port);
      rd(vt[i].port, vt[i].cnt, vt[i].sum, vt[i].mn, vt[i].mx);
    end

    pulse(1'b0, 1'b1);
    t0 = tb_now - 16'd1;
    chk("drain_enter", 64'(state_o), 64'd2);
    wait_until(t0 + 16'd100, "drain100");
    send(0, 7, 1'b1, 1'b1, 0);
    rd(0, 32'd2, 48'd7, 16'd0, 16'd7);
    pulse(1'b1, 1'b0);
    chk("start_ignored_drain", 64'(state_o), 64'd2);
    wait_until(t0 + 16'd1024, "drain_last");
    chk("drain_last_cycle", 64'(state_o), 64'd2);
    @(negedge clk);
    chk("done_after_1024", 64'(state_o), 64'd3);
    send(0, 4, 1'b1, 1'b1, 0);
    rd(0, 32'd2, 48'd7, 16'd0, 16'd7);

    pkt[1] = '{valid: 1'b1, measure: 1'b1, dest: DEST_W'(1), timestamp: tb_now - 16'd3};
    pulse(1'b1, 1'b0);
    pkt[1] = '0;
    chk("restart_measure", 64'(state_o), 64'd1);
    rd(1, 32'd0, 48'd0, 16'hFFFF, 16'd0);
    rd(2, 32'd0, 48'd0, 16'hFFFF, 16'd0);

    for (int p = 0; p < NP; p++)
      pkt[p] = '{valid: 1'b1, measure: 1'b1, dest: DEST_W'(p), timestamp: tb_now - 16'(p + 1)};
    @(negedge clk);
    clear_pkts();
    for (int p = 0; p < NP; p++)
      rd(p, 32'd1, 48'(p + 1), 16'(p + 1), 16'(p + 1));
    for (int p = NP; p < (1 << RD_W); p++)
      rd(p, 32'd0, 48'd0, 16'd0, 16'd0);

    pulse(1'b1, 1'b1);
    chk("stop_wins_measure", 64'(state_o), 64'd2);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_to_idle", 64'(state_o), 64'd0);
    pulse(1'b1, 1'b1);
    chk("start_wins_idle", 64'(state_o), 64'd1);
    send(NP - 1, 6, 1'b1, 1'b1, NP - 1);
    rd(NP - 1, 32'd1, 48'd6, 16'd6, 16'd6);
    rst = 1'b1;
    #1;
    chk("async_reset_state", 64'(state_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(NP - 1, 32'd0, 48'd0, 16'hFFFF, 16'd0);

    pulse(1'b1, 1'b0);
    send(3, 2, 1'b1, 1'b0, 1);
    chk("misroute_set", 64'(misroute_err), 64'(MR_EXP));
    @(negedge clk);
    chk("misroute_sticky", 64'(misroute_err), 64'(MR_EXP));
    rd(3, 32'd0, 48'd0, 16'hFFFF, 16'd0);
    pulse(1'b0, 1'b1);
    t0 = tb_now - 16'd1;
    wait_until(t0 + 16'd1030, "drain2");
    chk("done_again", 64'(state_o), 64'd3);
    chk("misroute_in_done", 64'(misroute_err), 64'(MR_EXP));
    pulse(1'b1, 1'b0);
    chk("misroute_cleared", 64'(misroute_err), 64'd0);

    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/noc_sink_monitor.md
Name: noc_sink_monitor

Overview:
- Downstream consumer of the network top's per-port output packets (pkt_out).
- Supplies the free-running timestamp that the upstream traffic generators stamp into packets.
- Counts delivered measurement packets per port and accumulates latency statistics over a start/stop measurement window.
- Exposes results through a one-cycle-latency read port to the emulation controller.

Parameters:
- PORTS, `PORTS, number of network ports monitored.
- TS_WIDTH, 16, width of time_now and of packet_t.timestamp; the two must be equal.
- CNT_WIDTH, 32, width of per-port packet counters.
- ACC_WIDTH, 48, width of per-port latency accumulators.
- DRAIN_CYCLES, 1024, cycles spent in DRAIN after stop before entering DONE.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- pkt_out  input  packet_t [0:PORTS-1]  packets delivered by the network; packet_t fields used: valid, measure, dest, timestamp.
- start  input  1  pulse; opens the measurement window.
- stop  input  1  pulse; closes the measurement window.
- time_now  output  TS_WIDTH  free-running cycle counter.
- state_o  output  2  IDLE=0, MEASURE=1, DRAIN=2, DONE=3.
- rd_en  input  1  read request.
- rd_port  input  $clog2(PORTS)  port selected for read.
- rd_valid  output  1  read data valid.
- rd_count  output  CNT_WIDTH  packets counted on the selected port.
- rd_lat_sum  output  ACC_WIDTH  summed latency on the selected port.
- rd_lat_min  output  TS_WIDTH  minimum latency on the selected port.
- rd_lat_max  output  TS_WIDTH  maximum latency on the selected port.
- misroute_err  output  1  sticky misroute flag (optional feature only).

Behaviour:
- Reset (asynchronous, active-high), all outputs and state take these values:
  - time_now=0; state IDLE.
  - All counters and sums 0; all lat_min all-ones; all lat_max 0.
  - rd_valid=0; all rd_* data outputs 0; misroute_err=0.
- time_now increments by 1 every cycle in every state and wraps from 2^TS_WIDTH-1 to 0.
- FSM transitions:
  - IDLE --start--> MEASURE. Entering MEASURE clears all per-port stats (counts/sums 0, min all-ones, max 0) in the same edge.
  - MEASURE --stop--> DRAIN. The drain counter loads DRAIN_CYCLES-1.
  - DRAIN counts down and moves to DONE on the cycle after the counter reaches 0, i.e. exactly DRAIN_CYCLES cycles are spent in DRAIN.
  - DONE --start--> MEASURE, which clears stats again.
  - start is ignored in MEASURE and DRAIN. stop is ignored outside MEASURE.
  - start and stop in the same cycle: start takes precedence in IDLE/DONE; stop takes precedence in MEASURE.
- Packet accounting, per port p, on each cycle:
  - A packet is counted when pkt_out[p].valid && pkt_out[p].measure && state is MEASURE or DRAIN. Packets arriving on the clearing edge (IDLE/DONE->MEASURE) are not counted.
  - lat = (time_now - pkt_out[p].timestamp) mod 2^TS_WIDTH; wrap of time_now is handled by the modulo arithmetic.
  - count += 1, saturating at all-ones.
  - sum += lat, zero-extended to ACC_WIDTH, saturating at all-ones.
  - min = min(min, lat); max = max(max, lat).
  - All ports update independently in the same cycle; no arbitration is needed.
  - Non-measure or invalid packets are consumed and ignored. The block never back-pressures the network.
- Readout:
  - rd_en sampled at edge N gives rd_valid=1 and the stats of rd_port during cycle N+1. Values are those registered at edge N, before any update from the same edge.
  - rd_valid=0 in any cycle following a cycle without rd_en; rd_* data outputs hold their last values.
  - rd_port >= PORTS returns zeros with rd_valid=1.
  - Reads are legal in every state.
- Reset mid-measurement aborts immediately to IDLE with stats cleared.

Optional Feature:
- NOC_SINK_MISROUTE_CHECK_EN defined:
  - Any valid packet on port p (regardless of measure flag or state) with dest != p sets misroute_err.
  - The flag is sticky until reset or until the next entry into MEASURE.
- NOC_SINK_MISROUTE_CHECK_EN undefined: misroute_err is tied 0 and the dest field is not read.

Test Plan:
1. Reset then idle 70000 cycles -> time_now wraps at 65535->0; state_o=0; rd of port 0 returns count=0, min=0xFFFF, max=0.
2. start; on port 2 inject measure packets with latencies 5, 9, 3; read port 2 -> count=3, sum=17, min=3, max=9, rd_valid one cycle after rd_en.
3. Packet stamped at time 65530 arrives when time_now=4 -> latency 10 recorded.
4. stop, then a measure packet arrives at DRAIN cycle 100 -> counted. state_o=3 exactly 1024 cycles after stop. A packet in DONE is not counted.
5. All ports receive a measure packet in the same cycle -> every port count +1; start in DONE clears all stats; start+stop together in IDLE enters MEASURE.
6. With NOC_SINK_MISROUTE_CHECK_EN, a packet dest=1 on port 3 -> misroute_err=1 from the next cycle until the next start; without the macro -> misroute_err stays 0.
